// File: rtl/mc_switch_cfg.sv
// ---------------------------------------------------------------------------
// mc_switch_cfg
//
// Configuration front-end for a 32x32 crosspoint switch. Commands edit a
// 1024-bit shadow matrix. A commit copies the shadow into the active matrix,
// and the active matrix drives the switch fabric. The fabric therefore only
// ever sees whole, consistent configurations.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : synchronous, active-high
//   io_cmdValid  : command present
//   io_cmdReady  : command accepted on io_cmdValid & io_cmdReady (IDLE only)
//   io_cmdOp     : 00 CONNECT, 01 DISCONNECT, 10 CLEAR_ALL, 11 READ_ROW
//   io_cmdSrc    : source index (matrix row)
//   io_cmdDst    : destination index (bit within row)
//   io_commit    : one-cycle request to copy shadow -> active
//   io_rspValid  : readback data valid
//   io_rspReady  : readback data consumed
//   io_rspData   : shadow row captured when READ_ROW was accepted
//   io_Switch    : active matrix; bit s*32+d = source s routed to dest d
//   io_busy      : not IDLE, or a commit is still pending
// ---------------------------------------------------------------------------
module mc_switch_cfg #(
  parameter bit EXCLUSIVE = 1'b1  // 1: each destination has at most one source
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_cmdValid,
  output logic          io_cmdReady,
  input  logic [1:0]    io_cmdOp,
  input  logic [4:0]    io_cmdSrc,
  input  logic [4:0]    io_cmdDst,
  input  logic          io_commit,
  output logic          io_rspValid,
  input  logic          io_rspReady,
  output logic [31:0]   io_rspData,
  output logic [1023:0] io_Switch,
  output logic          io_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_CONNECT    = 2'b00,
    OP_DISCONNECT = 2'b01,
    OP_CLEAR_ALL  = 2'b10,
    OP_READ_ROW   = 2'b11
  } op_e;

  // Packed [row][bit] layout, so matrix bit s*32+d is simply m[s][d].
  typedef logic [31:0][31:0] matrix_t;

  state_e      state_q,     state_d;
  matrix_t     shadow_q,    shadow_d;
  matrix_t     active_q,    active_d;
  logic [4:0]  row_q,       row_d;
  logic        pending_q,   pending_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q,  rsp_data_d;

  logic cmd_ready;
  logic cmd_fire;

  // A pending commit owns the first IDLE cycle, so commands wait for it.
  assign cmd_ready = (state_q == ST_IDLE) && !pending_q;
  assign cmd_fire  = io_cmdValid && cmd_ready;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    row_d       = row_q;
    pending_d   = pending_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          // Deferred commit. A fresh io_commit this cycle merges into it.
          active_d  = shadow_q;
          pending_d = 1'b0;
        end else if (cmd_fire) begin
          unique case (op_e'(io_cmdOp))
            OP_CONNECT: begin
              if (EXCLUSIVE) begin
                for (int r = 0; r < 32; r++) begin
                  shadow_d[r][io_cmdDst] = 1'b0;
                end
              end
              shadow_d[io_cmdSrc][io_cmdDst] = 1'b1;
            end
            OP_DISCONNECT: begin
              shadow_d[io_cmdSrc][io_cmdDst] = 1'b0;
            end
            OP_CLEAR_ALL: begin
              row_d   = 5'd0;
              state_d = ST_CLEAR;
            end
            OP_READ_ROW: begin
              rsp_data_d  = shadow_q[io_cmdSrc];
              rsp_valid_d = 1'b1;
              state_d     = ST_RESP;
            end
            default: ;
          endcase
          // A commit that lands on a command edge must see the edited shadow.
          if (io_commit) pending_d = 1'b1;
        end else if (io_commit) begin
          active_d = shadow_q;
        end
      end

      ST_CLEAR: begin
        shadow_d[row_q] = '0;
        if (row_q == 5'd31) begin
          // Stop at row 31 rather than letting the counter wrap.
          row_d   = 5'd0;
          state_d = ST_IDLE;
        end else begin
          row_d = row_q + 5'd1;
        end
        if (io_commit) pending_d = 1'b1;
      end

      ST_RESP: begin
        if (rsp_valid_q && io_rspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
        if (io_commit) pending_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // NOTE: both matrices sit in this reset branch on purpose: after reset the
  // fabric must see an empty matrix, so they are real reset flops, not RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses <= so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      active_q    <= '0;
      row_q       <= 5'd0;
      pending_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      row_q       <= row_d;
      pending_q   <= pending_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign io_cmdReady = cmd_ready;
  assign io_rspValid = rsp_valid_q;
  assign io_rspData  = rsp_data_q;
  assign io_Switch   = active_q;
  assign io_busy     = (state_q != ST_IDLE) || pending_q;

endmodule
